// File: rtl/plab3_mem_nsbittestmemory.sv
// Line-granular test memory answering one memreq at a time after a fixed latency.
// Each line carries an owner bit; non-secure requesters cannot read or overwrite secure-owned lines.
module plab3_mem_nsbittestmemory #(
  parameter int p_opaque_nbits = 8,
  parameter int p_abw          = 32,
  parameter int p_clw          = 128,
  parameter int p_nlines       = 16,
  parameter int p_latency      = 2,
  localparam int c_lenw        = $clog2(p_clw / 8),
  localparam int c_req_nbits   = 3 + p_opaque_nbits + p_abw + c_lenw + p_clw,
  localparam int c_resp_nbits  = 3 + p_opaque_nbits + c_lenw + p_clw
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    memreq_val,
  output logic                    memreq_rdy,
  input  logic [c_req_nbits-1:0]  memreq_msg,
  input  logic                    memreq_domain,
  output logic                    memresp_val,
  input  logic                    memresp_rdy,
  output logic [c_resp_nbits-1:0] memresp_msg,
  output logic                    memresp_domain,
  output logic [7:0]              violation_count,
  output logic [1:0]              o_dbg_state
);

  localparam int c_iw = $clog2(p_nlines);
  localparam int c_cw = (p_latency < 2) ? 1 : $clog2(p_latency + 1);
  localparam logic [c_cw-1:0] c_lat = c_cw'(p_latency);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]                r_state;
  logic [c_cw-1:0]           r_count;
  logic [2:0]                r_type;
  logic [p_opaque_nbits-1:0] r_opaque;
  logic [p_clw-1:0]          r_rdata;
  logic                      r_domain;
  logic [7:0]                r_viol;
  logic [p_clw-1:0]          r_mem [p_nlines];
  logic [p_nlines-1:0]       r_owner;

  logic [p_clw-1:0]          w_req_data;
  logic [p_abw-1:0]          w_req_addr;
  logic [p_opaque_nbits-1:0] w_req_opaque;
  logic [2:0]                w_req_type;
  logic [c_iw-1:0]           w_idx;
  logic                      w_accept;
  logic                      w_blocked;
  logic                      w_is_write;
  logic                      w_unused;

  assign w_req_data   = memreq_msg[p_clw-1:0];
  assign w_req_addr   = memreq_msg[p_clw+c_lenw +: p_abw];
  assign w_req_opaque = memreq_msg[p_clw+c_lenw+p_abw +: p_opaque_nbits];
  assign w_req_type   = memreq_msg[c_req_nbits-1 -: 3];
  // Whole-line accesses: byte offset, len and upper address bits play no part.
  assign w_idx        = w_req_addr[4 +: c_iw];
  assign w_unused     = ^{w_req_addr, memreq_msg[p_clw +: c_lenw]};

  assign w_accept   = memreq_val && memreq_rdy;
  assign w_blocked  = memreq_domain && !r_owner[w_idx];
  assign w_is_write = (w_req_type == 3'd1);

  // Handshake: a transfer occurs on a rising edge where val and rdy are both high;
  // the responder holds msg/domain stable while val is high and rdy is low.
  assign memreq_rdy     = (r_state == S_IDLE);
  assign memresp_val    = (r_state == S_RESP);
  assign memresp_msg    = {r_type, r_opaque, {c_lenw{1'b0}}, r_rdata};
  assign memresp_domain = r_domain;
  assign violation_count = r_viol;
  assign o_dbg_state    = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_type   <= '0;
      r_opaque <= '0;
      r_rdata  <= '0;
      r_domain <= 1'b0;
      r_viol   <= '0;
      r_owner  <= '1;
      for (int i = 0; i < p_nlines; i++) r_mem[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_type   <= w_req_type;
            r_opaque <= w_req_opaque;
            r_domain <= memreq_domain;
            r_count  <= c_lat;
            r_state  <= (p_latency == 0) ? S_RESP : S_WAIT;
            // Blocked accesses return zero and leave the line untouched.
            if (w_blocked) begin
              r_rdata <= '0;
              if (r_viol != 8'hFF) r_viol <= r_viol + 8'd1;
            end else if (w_is_write) begin
              r_rdata        <= '0;
              r_mem[w_idx]   <= w_req_data;
              r_owner[w_idx] <= memreq_domain;
            end else begin
              r_rdata <= r_mem[w_idx];
            end
          end
        end
        S_WAIT: begin
          if (r_count == c_cw'(1)) r_state <= S_RESP;
          else                     r_count <= r_count - c_cw'(1);
        end
        S_RESP: begin
          if (memresp_rdy) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plab3_mem_nsbittestmemory.sv
// Bench for the NS-bit test memory: a latency-2 and a latency-0 instance share one
// stimulus path selected by sel; expectations come from tables and an array model.
module tb_plab3_mem_nsbittestmemory;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         sel;
  logic         t_val, t_dom, t_rrdy;
  logic [174:0] t_msg;

  logic         a_req_val, a_req_rdy, a_resp_val, a_resp_rdy, a_resp_dom;
  logic [142:0] a_resp_msg;
  logic [7:0]   a_viol;
  logic [1:0]   a_dbg;
  logic         b_req_val, b_req_rdy, b_resp_val, b_resp_rdy, b_resp_dom;
  logic [142:0] b_resp_msg;
  logic [7:0]   b_viol;
  logic [1:0]   b_dbg;

  logic         v_req_rdy, v_resp_val, v_resp_dom;
  logic [142:0] v_resp_msg;
  logic [7:0]   v_viol;

  assign a_req_val  = t_val & ~sel;
  assign a_resp_rdy = t_rrdy & ~sel;
  assign b_req_val  = t_val & sel;
  assign b_resp_rdy = t_rrdy & sel;
  assign v_req_rdy  = sel ? b_req_rdy  : a_req_rdy;
  assign v_resp_val = sel ? b_resp_val : a_resp_val;
  assign v_resp_dom = sel ? b_resp_dom : a_resp_dom;
  assign v_resp_msg = sel ? b_resp_msg : a_resp_msg;
  assign v_viol     = sel ? b_viol     : a_viol;

  plab3_mem_nsbittestmemory #(.p_latency(2)) dut_a (
    .clk(clk), .reset(reset),
    .memreq_val(a_req_val), .memreq_rdy(a_req_rdy), .memreq_msg(t_msg), .memreq_domain(t_dom),
    .memresp_val(a_resp_val), .memresp_rdy(a_resp_rdy), .memresp_msg(a_resp_msg),
    .memresp_domain(a_resp_dom), .violation_count(a_viol), .o_dbg_state(a_dbg)
  );

  plab3_mem_nsbittestmemory #(.p_latency(0)) dut_b (
    .clk(clk), .reset(reset),
    .memreq_val(b_req_val), .memreq_rdy(b_req_rdy), .memreq_msg(t_msg), .memreq_domain(t_dom),
    .memresp_val(b_resp_val), .memresp_rdy(b_resp_rdy), .memresp_msg(b_resp_msg),
    .memresp_domain(b_resp_dom), .violation_count(b_viol), .o_dbg_state(b_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain arrays indexed by line number.
  logic [127:0] mdl_mem [16];
  logic         mdl_own [16];
  int           mdl_viol;

  task automatic mdl_reset();
    for (int i = 0; i < 16; i++) begin
      mdl_mem[i] = '0;
      mdl_own[i] = 1'b1;
    end
    mdl_viol = 0;
  endtask

  function automatic logic [127:0] mdl_access(input logic [2:0] ty, input logic dom,
                                              input logic [31:0] addr, input logic [127:0] wd);
    int idx;
    idx = (addr / 16) % 16;
    if (dom == 1'b1 && mdl_own[idx] == 1'b0) begin
      if (mdl_viol < 255) mdl_viol = mdl_viol + 1;
      return '0;
    end
    if (ty == 3'd1) begin
      mdl_mem[idx] = wd;
      mdl_own[idx] = dom;
      return '0;
    end
    return mdl_mem[idx];
  endfunction

  task automatic do_reset();
    t_val  = 1'b0;
    t_rrdy = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One full transaction on the selected instance, starting and ending at a negedge in IDLE.
  task automatic do_txn(input logic [2:0] ty, input logic dom, input logic [31:0] addr,
                        input logic [127:0] wd, input logic [7:0] opq,
                        input logic [127:0] exp_d, input int exp_v, input int hold,
                        input string tag);
    int           lat;
    int           cyc;
    logic [142:0] snap_msg;
    logic         snap_dom;
    logic         stable;
    lat = sel ? 0 : 2;
    chk({tag, " req_rdy idle"}, v_req_rdy, 1);
    t_msg  = {ty, opq, addr, 4'($urandom), wd};
    t_dom  = dom;
    t_val  = 1'b1;
    t_rrdy = 1'b0;
    @(negedge clk);
    t_val = 1'b0;
    cyc = 1;
    while (!v_resp_val && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, cyc, lat + 1);
    snap_msg = v_resp_msg;
    snap_dom = v_resp_dom;
    stable   = 1'b1;
    for (int h = 0; h < hold; h++) begin
      t_val = 1'b1;
      t_msg = {3'd1, 8'hEE, 32'h40, 4'h0, {4{$urandom}}};
      @(negedge clk);
      if (v_resp_msg !== snap_msg || v_resp_dom !== snap_dom ||
          v_req_rdy !== 1'b0 || v_resp_val !== 1'b1) stable = 1'b0;
    end
    t_val = 1'b0;
    if (hold > 0) chk({tag, " hold stable"}, stable, 1);
    chk({tag, " resp_msg"}, v_resp_msg, {ty, opq, 4'h0, exp_d});
    chk({tag, " resp_dom"}, v_resp_dom, dom);
    chk({tag, " viol"}, v_viol, exp_v);
    t_rrdy = 1'b1;
    @(negedge clk);
    t_rrdy = 1'b0;
    chk({tag, " val after hs"}, v_resp_val, 0);
    chk({tag, " rdy after hs"}, v_req_rdy, 1);
  endtask

  typedef struct {
    logic [2:0]   ty;
    logic         dom;
    logic [31:0]  addr;
    logic [127:0] wd;
    logic [7:0]   opq;
    logic [127:0] exp_d;
    int           exp_v;
    int           hold;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [127:0] d1, d2, d3, a5, ff, de, exp_d;
    logic [2:0]   ty;
    logic         dom, stayed;
    logic [31:0]  addr;
    logic [127:0] wd;
    int           r;

    d1 = 128'h11223344_55667788_99AABBCC_DDEEFF00;
    d2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    d3 = 128'hCAFEF00D_0BADBEEF_13579BDF_2468ACE0;
    a5 = {16{8'hA5}};
    ff = {16{8'hFF}};
    de = {4{32'hDEADBEEF}};

    tbl[0]  = '{3'd1, 1'b1, 32'h0000_0040, d1, 8'h05, '0, 0, 0};
    tbl[1]  = '{3'd0, 1'b1, 32'h0000_0040, '0, 8'h06, d1, 0, 0};
    tbl[2]  = '{3'd1, 1'b0, 32'h0000_0080, a5, 8'h07, '0, 0, 0};
    tbl[3]  = '{3'd0, 1'b1, 32'h0000_0080, '0, 8'h08, '0, 1, 0};
    tbl[4]  = '{3'd1, 1'b1, 32'h0000_0080, ff, 8'h09, '0, 2, 0};
    tbl[5]  = '{3'd0, 1'b0, 32'h0000_0080, '0, 8'h0A, a5, 2, 0};
    tbl[6]  = '{3'd1, 1'b1, 32'h0000_0010, d2, 8'h0B, '0, 2, 0};
    tbl[7]  = '{3'd0, 1'b1, 32'h0000_0110, '0, 8'h0C, d2, 2, 5};
    tbl[8]  = '{3'd3, 1'b1, 32'h0000_0040, de, 8'h0D, d1, 2, 1};
    tbl[9]  = '{3'd0, 1'b1, 32'h0000_0040, '0, 8'h0E, d1, 2, 0};
    tbl[10] = '{3'd1, 1'b0, 32'h0000_0040, d3, 8'h0F, '0, 2, 0};
    tbl[11] = '{3'd0, 1'b1, 32'h0000_0040, '0, 8'h10, '0, 3, 2};
    tbl[12] = '{3'd5, 1'b1, 32'h0000_0080, '0, 8'h11, '0, 4, 0};
    tbl[13] = '{3'd0, 1'b0, 32'h0000_2040, '0, 8'h12, d3, 4, 0};

    sel    = 1'b0;
    t_val  = 1'b0;
    t_dom  = 1'b0;
    t_rrdy = 1'b0;
    t_msg  = '0;
    do_reset();

    chk("reset a req_rdy",  a_req_rdy,  1);
    chk("reset a resp_val", a_resp_val, 0);
    chk("reset a resp_msg", a_resp_msg, 0);
    chk("reset a resp_dom", a_resp_dom, 0);
    chk("reset a viol",     a_viol,     0);
    chk("reset b req_rdy",  b_req_rdy,  1);
    chk("reset b resp_val", b_resp_val, 0);
    chk("reset b resp_msg", b_resp_msg, 0);
    chk("reset b viol",     b_viol,     0);

    for (int i = 0; i < 14; i++)
      do_txn(tbl[i].ty, tbl[i].dom, tbl[i].addr, tbl[i].wd, tbl[i].opq,
             tbl[i].exp_d, tbl[i].exp_v, tbl[i].hold, $sformatf("tbl%0d", i));

    // Reset while the latency-2 instance is waiting: the transaction must vanish.
    t_msg = {3'd1, 8'h21, 32'h30, 4'h0, d1};
    t_dom = 1'b0;
    t_val = 1'b1;
    @(negedge clk);
    t_val = 1'b0;
    reset = 1'b1;
    stayed = !v_resp_val;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (v_resp_val) stayed = 1'b0;
      @(negedge clk);
    end
    chk("abort no resp", stayed, 1);
    chk("abort req_rdy", v_req_rdy, 1);
    chk("abort viol", v_viol, 0);
    mdl_reset();
    exp_d = mdl_access(3'd0, 1'b1, 32'h80, '0);
    do_txn(3'd0, 1'b1, 32'h80, '0, 8'h22, exp_d, mdl_viol, 0, "post-abort 0x80");
    exp_d = mdl_access(3'd0, 1'b1, 32'h30, '0);
    do_txn(3'd0, 1'b1, 32'h30, '0, 8'h23, exp_d, mdl_viol, 0, "post-abort 0x30");

    // Random traffic against the model, on each instance.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset();
      mdl_reset();
      if (s == 1) begin
        // Back-to-back requests with response ready tied high: accept every other cycle.
        t_msg  = {3'd0, 8'h31, 32'h20, 4'h0, 128'h0};
        t_dom  = 1'b1;
        t_val  = 1'b1;
        t_rrdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
          chk($sformatf("b2b rdy c%0d", c), v_req_rdy, (c % 2 == 0));
          chk($sformatf("b2b val c%0d", c), v_resp_val, (c % 2 == 1));
          @(negedge clk);
        end
        t_val  = 1'b0;
        t_rrdy = 1'b0;
        @(negedge clk);
      end
      for (int n = 0; n < 80; n++) begin
        r = $urandom_range(0, 9);
        ty = (r < 4) ? 3'd0 : (r < 8) ? 3'd1 : 3'($urandom_range(2, 7));
        dom = 1'($urandom_range(0, 1));
        addr = $urandom;
        wd = {$urandom, $urandom, $urandom, $urandom};
        exp_d = mdl_access(ty, dom, addr, wd);
        do_txn(ty, dom, addr, wd, 8'($urandom), exp_d, mdl_viol, $urandom_range(0, 2),
               $sformatf("rnd%0d_%0d", s, n));
      end
    end

    // Saturation of the violation counter on the latency-0 instance.
    exp_d = mdl_access(3'd1, 1'b0, 32'h0, d2);
    do_txn(3'd1, 1'b0, 32'h0, d2, 8'h40, exp_d, mdl_viol, 0, "sat claim");
    for (int n = 0; n < 260; n++) begin
      exp_d = mdl_access(3'd0, 1'b1, 32'h5000, '0);
      do_txn(3'd0, 1'b1, 32'h5000, '0, 8'h41, exp_d, mdl_viol, 0, $sformatf("sat%0d", n));
    end
    chk("sat final", v_viol, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/plab3_mem_nsbittestmemory.md
Name:
plab3_mem_NSbitTestMemory

Overview:
- Cacheline-granular backing memory. It is the responder end of the memreq/memresp interface driven by the blocking cache datapath.
- Accepts one 128-bit line request at a time, holds it for a programmable latency, then returns a memresp tagged with the requester's domain.
- Each line carries an NS-bit owner tag. Non-secure (domain 1) requests cannot read or overwrite secure-owned (domain 0) lines.

Parameters:
p_opaque_nbits, 8, opaque field width (o)
p_abw, 32, address width
p_clw, 128, line/data width
p_nlines, 16, number of lines in memory
p_latency, 2, extra wait cycles between request accept and response valid (0 allowed)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
memreq_val  in  1  request valid
memreq_rdy  out  1  request ready
memreq_msg  in  VC_MEM_REQ_MSG_NBITS(o,abw,clw) (175)  fields {type[2:0], opaque, addr, len, data}, MSB->LSB
memreq_domain  in  1  requester domain: 0 = secure, 1 = non-secure
memresp_val  out  1  response valid
memresp_rdy  in  1  response ready
memresp_msg  out  VC_MEM_RESP_MSG_NBITS(o,clw) (143)  fields {type, opaque, len, data}
memresp_domain  out  1  domain of the request being answered
violation_count  out  8  saturating count of blocked accesses

Behaviour:
- Single clock, clk. reset is synchronous and active-high.
- Reset: state=IDLE, memreq_rdy=1, memresp_val=0, memresp_msg=0, memresp_domain=0, violation_count=0, all line data=0, all owner bits=1 (non-secure).
- Line index = addr[4+$clog2(p_nlines)-1:4]. Upper address bits are ignored (aliasing wrap). addr[3:0] and len are ignored; every access is a full line.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - memreq_rdy=1.
  - On val&&rdy, latch type, opaque, index, data and domain, and perform the array access in that same cycle.
  - Go to WAIT with count=p_latency; if p_latency==0, go directly to RESP.
- WAIT:
  - memreq_rdy=0. count decrements each cycle.
  - When count==1, go to RESP on the next edge.
  - Response valid therefore appears exactly p_latency+1 cycles after the accept edge.
- RESP:
  - memresp_val=1. Message and domain stay stable until memresp_rdy.
  - On val&&rdy, go to IDLE. The next request can be accepted on the following cycle; there is no same-cycle turnaround.
- Read (type 0):
  - If domain==1 and owner==0: response data=0 and violation_count increments.
  - Otherwise response data = the line contents.
- Write (type 1):
  - If domain==1 and owner==0: the write is dropped and violation_count increments.
  - Otherwise data is written and owner is set to domain. Secure writes claim the line; non-secure writes to NS lines keep owner=1.
  - Write response data=0.
- Other type codes: treated as a read, with no array modification. The type is echoed in the response.
- Response fields: type = latched type, opaque = latched opaque, len = 0, memresp_domain = latched domain.
- violation_count saturates at 255.
- Reset asserted in WAIT or RESP aborts the transaction: no response is issued. Array contents updated at accept are not reverted except by the reset itself.
- memreq_val while not in IDLE is ignored (rdy=0). memresp_rdy held high early has no effect until RESP.

Test Plan:
- p_latency=2: write from domain 1, addr 0x0000_0040, data 0x11223344_55667788_99AABBCC_DDEEFF00, opaque 0x05. Response valid 3 cycles after accept: type 1, opaque 0x05, data 0, domain 1. A following read from domain 1 of the same address returns that data.
- Secure write (domain 0) to addr 0x80, data 0xA5…A5. Then NS read of 0x80 -> data 0, violation_count=1. NS write of 0x80 with 0xFF…FF -> dropped, count=2. Secure read of 0x80 -> 0xA5…A5.
- Aliasing: write addr 0x0000_0010, then read addr 0x0000_0110 (p_nlines=16) -> same line data returned.
- Backpressure: hold memresp_rdy=0 for 5 cycles in RESP -> msg and domain stable, memreq_rdy=0 throughout. Raise rdy -> handshake, IDLE next cycle, memreq_rdy=1.
- p_latency=0: accept at edge N -> memresp_val=1 at N+1. Back-to-back requests are accepted every 2 cycles with memresp_rdy tied high.
- Assert reset during WAIT -> memresp_val stays 0, memreq_rdy=1 after reset, violation_count=0, all owner bits=1 (a subsequent NS read of any line is not blocked).
